// File: rtl/scan2ascii_stream.sv
// PS/2 set-2 scan code to ASCII translator with E0/F0 prefix decoding,
// Shift/Caps Lock tracking and a valid/ready output FIFO.
module scan2ascii_stream #(
  parameter int   FIFO_DEPTH   = 8,
  parameter logic CAPS_DEFAULT = 1'b0,
  parameter logic EMIT_UNKNOWN = 1'b0
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic [7:0]                  SCAN_CODE,
  input  logic                        SCAN_VALID,
  output logic [7:0]                  ASCII_CODE,
  output logic                        ASCII_VALID,
  input  logic                        ASCII_READY,
  output logic                        SHIFT_ACTIVE,
  output logic                        CAPS_LOCK,
  output logic                        OVERFLOW,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t          state_q, state_d;
  logic            lshift_q, lshift_d, rshift_q, rshift_d;
  logic            caps_q, caps_d, caps_held_q, caps_held_d;
  logic            push_q, push_d;
  logic [7:0]      char_q, char_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            ovf_q;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [8:0]      dec;
  logic            pop, full, wr_en;

  // Returns {hit, ascii} for a make code seen with no prefix pending.
  function automatic logic [8:0] decode_make(input logic [7:0] sc, input logic sh, input logic up);
    logic [7:0] lc;
    lc = 8'h00;
    decode_make = {EMIT_UNKNOWN, 8'h3F};
    case (sc)
      8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";  8'h23: lc = "d";
      8'h24: lc = "e";  8'h2B: lc = "f";  8'h34: lc = "g";  8'h33: lc = "h";
      8'h43: lc = "i";  8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
      8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";  8'h4D: lc = "p";
      8'h15: lc = "q";  8'h2D: lc = "r";  8'h1B: lc = "s";  8'h2C: lc = "t";
      8'h3C: lc = "u";  8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
      8'h35: lc = "y";  8'h1A: lc = "z";
      default: lc = 8'h00;
    endcase
    if (lc != 8'h00) begin
      decode_make = {1'b1, up ? (lc - 8'h20) : lc};
    end else begin
      case (sc)
        8'h16: decode_make = {1'b1, sh ? "!" : "1"};
        8'h1E: decode_make = {1'b1, sh ? "@" : "2"};
        8'h26: decode_make = {1'b1, sh ? "#" : "3"};
        8'h25: decode_make = {1'b1, sh ? "$" : "4"};
        8'h2E: decode_make = {1'b1, sh ? "%" : "5"};
        8'h36: decode_make = {1'b1, sh ? "^" : "6"};
        8'h3D: decode_make = {1'b1, sh ? "&" : "7"};
        8'h3E: decode_make = {1'b1, sh ? "*" : "8"};
        8'h46: decode_make = {1'b1, sh ? "(" : "9"};
        8'h45: decode_make = {1'b1, sh ? ")" : "0"};
        8'h4E: decode_make = {1'b1, sh ? "_" : "-"};
        8'h55: decode_make = {1'b1, sh ? "+" : "="};
        8'h41: decode_make = {1'b1, sh ? "<" : ","};
        8'h49: decode_make = {1'b1, sh ? ">" : "."};
        8'h4A: decode_make = {1'b1, sh ? "?" : "/"};
        8'h52: decode_make = {1'b1, sh ? "\"" : "'"};
        8'h54: decode_make = {1'b1, sh ? "{" : "["};
        8'h5B: decode_make = {1'b1, sh ? "}" : "]"};
        8'h70: decode_make = {1'b1, "0"};
        8'h69: decode_make = {1'b1, "1"};
        8'h72: decode_make = {1'b1, "2"};
        8'h7A: decode_make = {1'b1, "3"};
        8'h6B: decode_make = {1'b1, "4"};
        8'h73: decode_make = {1'b1, "5"};
        8'h74: decode_make = {1'b1, "6"};
        8'h6C: decode_make = {1'b1, "7"};
        8'h75: decode_make = {1'b1, "8"};
        8'h7D: decode_make = {1'b1, "9"};
        8'h71: decode_make = {1'b1, "."};
        8'h7B: decode_make = {1'b1, "-"};
        8'h79: decode_make = {1'b1, "+"};
        8'h7C: decode_make = {1'b1, "*"};
        8'h29: decode_make = {1'b1, 8'h20};
        8'h5A: decode_make = {1'b1, 8'h0D};
        8'h66: decode_make = {1'b1, 8'h08};
        8'h0D: decode_make = {1'b1, 8'h09};
        default: decode_make = {EMIT_UNKNOWN, 8'h3F};
      endcase
    end
  endfunction

  assign SHIFT_ACTIVE = lshift_q | rshift_q;
  assign CAPS_LOCK    = caps_q;
  assign OVERFLOW     = ovf_q;
  assign FIFO_COUNT   = count_q;
  assign ASCII_VALID  = (count_q != '0);
  assign ASCII_CODE   = ASCII_VALID ? mem[rd_ptr_q] : 8'h00;

  assign pop   = ASCII_VALID & ASCII_READY;
  assign full  = (count_q == DEPTH_C);
  assign wr_en = push_q & (~full | pop);

  always_comb begin
    state_d     = state_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    push_d      = 1'b0;
    char_d      = 8'h00;
    dec         = decode_make(SCAN_CODE, SHIFT_ACTIVE, SHIFT_ACTIVE ^ caps_q);
    if (SCAN_VALID) begin
      if (SCAN_CODE == 8'hE0) begin
        if (state_q == IDLE) state_d = EXT;
      end else if (SCAN_CODE == 8'hF0) begin
        if (state_q == IDLE)     state_d = BRK;
        else if (state_q == EXT) state_d = EXT_BRK;
      end else begin
        state_d = IDLE;
        case (state_q)
          IDLE: begin
            case (SCAN_CODE)
              8'h12: lshift_d = 1'b1;
              8'h59: rshift_d = 1'b1;
              8'h58: begin
                // Typematic repeats of Caps Lock arrive as further makes; only the first toggles.
                if (!caps_held_q) caps_d = ~caps_q;
                caps_held_d = 1'b1;
              end
              default: begin
                push_d = dec[8];
                char_d = dec[7:0];
              end
            endcase
          end
          BRK: begin
            case (SCAN_CODE)
              8'h12:   lshift_d    = 1'b0;
              8'h59:   rshift_d    = 1'b0;
              8'h58:   caps_held_d = 1'b0;
              default: ;
            endcase
          end
          EXT: begin
            if (SCAN_CODE == 8'h4A) begin
              push_d = 1'b1;
              char_d = 8'h2F;
            end else if (SCAN_CODE == 8'h5A) begin
              push_d = 1'b1;
              char_d = 8'h0D;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_q      <= CAPS_DEFAULT;
      caps_held_q <= 1'b0;
      push_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      push_q      <= push_d;
      ovf_q       <= push_q & full & ~pop;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_en && !pop)      count_q <= count_q + 1'b1;
      else if (!wr_en && pop) count_q <= count_q - 1'b1;
    end
  end

  // Decoded character stage, then FIFO write one edge later.
  always_ff @(posedge CLK) begin
    char_q <= char_d;
    if (wr_en) mem[wr_ptr_q] <= char_q;
  end

endmodule

// File: tb/tb_scan2ascii_stream.sv
// Directed bench for scan2ascii_stream: decode, modifiers, prefixes, FIFO full/overflow, reset.
module tb_scan2ascii_stream;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [7:0] SCAN_CODE = 8'h00;
  logic       SCAN_VALID = 1'b0;
  logic [7:0] ASCII_CODE;
  logic       ASCII_VALID;
  logic       ASCII_READY = 1'b0;
  logic       SHIFT_ACTIVE;
  logic       CAPS_LOCK;
  logic       OVERFLOW;
  logic [3:0] FIFO_COUNT;

  int nerr = 0;
  int nchk = 0;
  int ovf_seen = 0;

  scan2ascii_stream #(
    .FIFO_DEPTH(8),
    .CAPS_DEFAULT(1'b0),
    .EMIT_UNKNOWN(1'b0)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .SCAN_CODE(SCAN_CODE),
    .SCAN_VALID(SCAN_VALID),
    .ASCII_CODE(ASCII_CODE),
    .ASCII_VALID(ASCII_VALID),
    .ASCII_READY(ASCII_READY),
    .SHIFT_ACTIVE(SHIFT_ACTIVE),
    .CAPS_LOCK(CAPS_LOCK),
    .OVERFLOW(OVERFLOW),
    .FIFO_COUNT(FIFO_COUNT)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (OVERFLOW) ovf_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Called 1ns after an edge; the byte is sampled at the next edge.
  task automatic send(input logic [7:0] c);
    SCAN_CODE  = c;
    SCAN_VALID = 1'b1;
    step();
    SCAN_VALID = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, 32'(ASCII_VALID), 32'd1);
    chk({tag, "_code"}, 32'(ASCII_CODE), 32'(exp));
    ASCII_READY = 1'b1;
    step();
    ASCII_READY = 1'b0;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_code", 32'(ASCII_CODE), 32'h00);
    chk("rst_valid", 32'(ASCII_VALID), 32'd0);
    chk("rst_ovf", 32'(OVERFLOW), 32'd0);
    chk("rst_count", 32'(FIFO_COUNT), 32'd0);
    chk("rst_shift", 32'(SHIFT_ACTIVE), 32'd0);
    chk("rst_caps", 32'(CAPS_LOCK), 32'd0);
    step();
    RESET_N = 1'b1;
    step();

    // 1: single 'a' with READY high, two-cycle latency
    ASCII_READY = 1'b1;
    send(8'h1C);
    chk("t1_valid_early", 32'(ASCII_VALID), 32'd0);
    step();
    chk("t1_valid", 32'(ASCII_VALID), 32'd1);
    chk("t1_code", 32'(ASCII_CODE), 32'h61);
    chk("t1_count1", 32'(FIFO_COUNT), 32'd1);
    step();
    chk("t1_count0", 32'(FIFO_COUNT), 32'd0);
    chk("t1_valid_off", 32'(ASCII_VALID), 32'd0);
    ASCII_READY = 1'b0;

    // 2: shift make/break
    send(8'h12);
    chk("t2_shift_on", 32'(SHIFT_ACTIVE), 32'd1);
    send(8'h1C);
    send(8'hF0);
    send(8'h1C);
    send(8'hF0);
    send(8'h12);
    chk("t2_shift_off", 32'(SHIFT_ACTIVE), 32'd0);
    send(8'h1C);
    step();
    chk("t2_count", 32'(FIFO_COUNT), 32'd2);
    pop_chk("t2_A", 8'h41);
    pop_chk("t2_a", 8'h61);
    chk("t2_empty", 32'(FIFO_COUNT), 32'd0);

    // 3: Caps Lock with typematic repeat, then shift^caps
    send(8'h58);
    chk("t3_caps_on", 32'(CAPS_LOCK), 32'd1);
    send(8'h58);
    chk("t3_caps_repeat", 32'(CAPS_LOCK), 32'd1);
    send(8'hF0);
    send(8'h58);
    chk("t3_caps_break", 32'(CAPS_LOCK), 32'd1);
    send(8'h1C);
    step();
    chk("t3_count", 32'(FIFO_COUNT), 32'd1);
    pop_chk("t3_A", 8'h41);
    send(8'h12);
    send(8'h1C);
    step();
    pop_chk("t3_shift_caps", 8'h61);
    send(8'hF0);
    send(8'h12);
    chk("t3_shift_off", 32'(SHIFT_ACTIVE), 32'd0);
    send(8'h58);
    send(8'hF0);
    send(8'h58);
    chk("t3_caps_off", 32'(CAPS_LOCK), 32'd0);

    // 4: extended codes, keypad, unmapped code dropped
    send(8'hE0); send(8'h5A);
    send(8'hE0); send(8'h4A);
    send(8'hE0); send(8'h75);
    send(8'h69);
    send(8'h07);
    send(8'h12);
    send(8'h69);
    send(8'hF0); send(8'h12);
    step();
    chk("t4_count", 32'(FIFO_COUNT), 32'd4);
    pop_chk("t4_enter", 8'h0D);
    pop_chk("t4_slash", 8'h2F);
    pop_chk("t4_kp1", 8'h31);
    pop_chk("t4_kp1_sh", 8'h31);
    chk("t4_empty", 32'(FIFO_COUNT), 32'd0);

    // 5: fill FIFO with READY low, one extra push overflows
    ovf_seen = 0;
    for (int i = 0; i < 9; i++) send(8'h1C);
    chk("t5_count_full", 32'(FIFO_COUNT), 32'd8);
    chk("t5_ovf_before", 32'(OVERFLOW), 32'd0);
    step();
    chk("t5_ovf_pulse", 32'(OVERFLOW), 32'd1);
    chk("t5_count_hold", 32'(FIFO_COUNT), 32'd8);
    step();
    chk("t5_ovf_end", 32'(OVERFLOW), 32'd0);
    chk("t5_ovf_once", 32'(ovf_seen), 32'd1);
    chk("t5_head", 32'(ASCII_CODE), 32'h61);
    chk("t5_head_valid", 32'(ASCII_VALID), 32'd1);

    // 6: push and pop together while full
    send(8'h1C);
    ASCII_READY = 1'b1;
    step();
    ASCII_READY = 1'b0;
    chk("t6_count", 32'(FIFO_COUNT), 32'd8);
    chk("t6_no_ovf", 32'(OVERFLOW), 32'd0);
    step();
    chk("t6_ovf_seen", 32'(ovf_seen), 32'd1);

    // 6b: reset mid-burst with caps, shift and a pending break prefix
    send(8'h58);
    chk("t6_caps_on", 32'(CAPS_LOCK), 32'd1);
    send(8'h12);
    send(8'hF0);
    SCAN_CODE  = 8'h1C;
    SCAN_VALID = 1'b1;
    #2;
    RESET_N = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(ASCII_VALID), 32'd0);
    chk("t6_rst_count", 32'(FIFO_COUNT), 32'd0);
    chk("t6_rst_caps", 32'(CAPS_LOCK), 32'd0);
    chk("t6_rst_shift", 32'(SHIFT_ACTIVE), 32'd0);
    chk("t6_rst_code", 32'(ASCII_CODE), 32'h00);
    SCAN_VALID = 1'b0;
    step();
    RESET_N = 1'b1;
    step();
    send(8'h1C);
    step();
    chk("t6_post_count", 32'(FIFO_COUNT), 32'd1);
    pop_chk("t6_post_a", 8'h61);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
